// File: rtl/vmm_output_deserializer_if.sv
// Bus bundle for vmm_output_deserializer: a 10-bit word stream in, one 4-word frame out.
// Defining VMM_DESER_ACK_EN adds the dout_ack / overflow pair.
interface vmm_output_deserializer_if #(
   parameter int WIDTH = 10
);
   // Handshake: a word is taken on every CLK edge with din_valid=1 (there is no
   // backpressure); sof marks the first word of a frame. dout_valid flags a
   // completed frame on dout0..dout3. In the ack build it is a level that holds
   // until a cycle with dout_ack=1.
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             sof;
   logic [WIDTH-1:0] dout0;
   logic [WIDTH-1:0] dout1;
   logic [WIDTH-1:0] dout2;
   logic [WIDTH-1:0] dout3;
   logic             dout_valid;
   logic             frame_err;
`ifdef VMM_DESER_ACK_EN
   logic             dout_ack;
   logic             overflow;

   modport master (
      output din, din_valid, sof, dout_ack,
      input  dout0, dout1, dout2, dout3, dout_valid, frame_err, overflow
   );

   modport slave (
      input  din, din_valid, sof, dout_ack,
      output dout0, dout1, dout2, dout3, dout_valid, frame_err, overflow
   );
`else
   modport master (
      output din, din_valid, sof,
      input  dout0, dout1, dout2, dout3, dout_valid, frame_err
   );

   modport slave (
      input  din, din_valid, sof,
      output dout0, dout1, dout2, dout3, dout_valid, frame_err
   );
`endif
endinterface

// File: rtl/vmm_output_deserializer.sv
// Reassembles 4-word frames (wire order din3,din2,din1,din0) with sof alignment and a gap timeout.
// Optional VMM_DESER_ACK_EN: level dout_valid held until dout_ack, with a sticky overflow flag.
module vmm_output_deserializer #(
   parameter int WIDTH   = 10,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8
) (
   input  logic                      CLK,
   input  logic                      Reset,
   vmm_output_deserializer_if.slave  bus,
   output logic                      dbg_state
);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Gap value at which one more idle cycle makes TIMEOUT idle cycles in a row.
   localparam logic [TO_W-1:0] GAP_LAST = TO_W'(TIMEOUT - 1);
   localparam bit              TO_EN    = (TIMEOUT != 0);

   state_t           state, state_n;
   logic [1:0]       cnt, cnt_n;
   logic [TO_W-1:0]  gap, gap_n;

   logic [WIDTH-1:0] sh3, sh2, sh1;
   logic [WIDTH-1:0] d0_q, d1_q, d2_q, d3_q;
   logic             dout_valid_q;
   logic             frame_err_q;

   logic             wr_sh3, wr_sh2, wr_sh1;
   logic             complete;
   logic             err_n;
   logic             timeout_hit;
   logic             drop;
   logic             accept;

   assign timeout_hit = TO_EN && (gap == GAP_LAST);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 2'd0;
         gap   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         gap   <= gap_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      gap_n    = gap;
      wr_sh3   = 1'b0;
      wr_sh2   = 1'b0;
      wr_sh1   = 1'b0;
      complete = 1'b0;
      err_n    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.din_valid) begin
               if (bus.sof) begin
                  wr_sh3  = 1'b1;
                  cnt_n   = 2'd1;
                  gap_n   = '0;
                  state_n = COLLECT;
               end else begin
                  // Word outside any frame: the frame it belonged to lost its sof.
                  err_n = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (bus.din_valid) begin
               gap_n = '0;
               if (bus.sof) begin
                  // Early sof: drop the partial frame and restart on this word.
                  err_n  = 1'b1;
                  wr_sh3 = 1'b1;
                  cnt_n  = 2'd1;
               end else begin
                  case (cnt)
                     2'd1: begin
                        wr_sh2 = 1'b1;
                        cnt_n  = 2'd2;
                     end
                     2'd2: begin
                        wr_sh1 = 1'b1;
                        cnt_n  = 2'd3;
                     end
                     default: begin
                        complete = 1'b1;
                        cnt_n    = 2'd0;
                        state_n  = IDLE;
                     end
                  endcase
               end
            end else if (timeout_hit) begin
               err_n   = 1'b1;
               cnt_n   = 2'd0;
               gap_n   = '0;
               state_n = IDLE;
            end else begin
               gap_n = gap + TO_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

`ifdef VMM_DESER_ACK_EN
   // A finished frame is lost only when the previous one is still unacknowledged.
   assign drop = complete & dout_valid_q & ~bus.dout_ack;
`else
   assign drop = 1'b0;
`endif
   assign accept = complete & ~drop;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         sh3          <= '0;
         sh2          <= '0;
         sh1          <= '0;
         d0_q         <= '0;
         d1_q         <= '0;
         d2_q         <= '0;
         d3_q         <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         if (wr_sh3) sh3 <= bus.din;
         if (wr_sh2) sh2 <= bus.din;
         if (wr_sh1) sh1 <= bus.din;
         if (accept) begin
            d3_q <= sh3;
            d2_q <= sh2;
            d1_q <= sh1;
            d0_q <= bus.din;
         end
         frame_err_q <= err_n;
`ifdef VMM_DESER_ACK_EN
         if (complete)
            dout_valid_q <= 1'b1;
         else if (bus.dout_ack)
            dout_valid_q <= 1'b0;
`else
         dout_valid_q <= complete;
`endif
      end
   end

`ifdef VMM_DESER_ACK_EN
   logic overflow_q;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         overflow_q <= 1'b0;
      else if (drop)
         overflow_q <= 1'b1;
   end

   assign bus.overflow = overflow_q;
`endif

   assign bus.dout0      = d0_q;
   assign bus.dout1      = d1_q;
   assign bus.dout2      = d2_q;
   assign bus.dout3      = d3_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign dbg_state      = state;

endmodule
